bloonpop_ctrl: RTL and testbench

Upstream controller for the bloon-pop sprite drawer.
- Accepts pop events from game logic and holds up to NUM_SLOTS concurrent pop effects, each lasting DURATION video frames.
- For every scanned pixel (DrawX, DrawY), selects the active effect covering that pixel and produces the sprite-relative coordinates RelativeXP/RelativeYP that drive the pop sprite ROM address.
- Produces a hit flag delay-matched to the drawer's RGB output, so the colour mux can choose pop colour vs. background.

---
 rtl/bloonpop_pkg.sv | 21 ++
 rtl/bloonpop_if.sv | 28 ++
 rtl/bloonpop_slot.sv | 65 ++++++
 rtl/bloonpop_ctrl.sv | 115 +++++++++++
 tb/tb_bloonpop_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bloonpop_pkg.sv
// Shared constants and slot record for the bloon-pop effect controller.
package bloonpop_pkg;

    localparam int unsigned COORD_W  = 10;
    localparam int unsigned FRAME_W  = 8;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned SPRITE_W = 32;
    localparam int unsigned SPRITE_H = 32;
    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic               active;
        coord_t             x;
        coord_t             y;
        logic [FRAME_W-1:0] frames_left;
    } pop_slot_t;

endpackage

// File: rtl/bloonpop_if.sv
// Game-logic / scan-side signal bundle of the bloon-pop controller.
interface bloonpop_if;
    import bloonpop_pkg::*;

    logic              frame_tick;
    coord_t            DrawX;
    coord_t            DrawY;
    logic              pop_req;
    coord_t            pop_x;
    coord_t            pop_y;
    coord_t            RelativeXP;
    coord_t            RelativeYP;
    logic              pop_hit;
    logic              pop_hit_rgb;
    logic              pop_drop;
    logic [CNT_W-1:0]  active_cnt;

    modport master (
        output frame_tick, DrawX, DrawY, pop_req, pop_x, pop_y,
        input  RelativeXP, RelativeYP, pop_hit, pop_hit_rgb, pop_drop, active_cnt
    );

    modport slave (
        input  frame_tick, DrawX, DrawY, pop_req, pop_x, pop_y,
        output RelativeXP, RelativeYP, pop_hit, pop_hit_rgb, pop_drop, active_cnt
    );

endinterface

// File: rtl/bloonpop_slot.sv
// One pop effect: position/lifetime registers, frame countdown and pixel hit test.
module bloonpop_slot
    import bloonpop_pkg::*;
#(
    parameter int unsigned DURATION = 8
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   tick,
    input  coord_t ld_x,
    input  coord_t ld_y,
    input  coord_t draw_x,
    input  coord_t draw_y,
    output logic   active,
    output logic   active_nxt_c,
    output logic   hit_c,
    output coord_t relx_c,
    output coord_t rely_c
);

    pop_slot_t st;
    pop_slot_t st_nxt;
    coord_t    dx;
    coord_t    dy;
    logic      in_x;
    logic      in_y;

    // Load only ever targets an idle slot, so it never competes with a countdown.
    always_comb begin
        st_nxt = st;
        if (load) begin
            st_nxt.active      = 1'b1;
            st_nxt.x           = ld_x;
            st_nxt.y           = ld_y;
            st_nxt.frames_left = FRAME_W'(DURATION);
        end else if (tick && st.active) begin
            st_nxt.frames_left = st.frames_left - FRAME_W'(1);
            if (st.frames_left == FRAME_W'(1)) begin
                st_nxt.active = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st <= '0;
        end else begin
            st <= st_nxt;
        end
    end

    // Offsets are only meaningful once draw >= origin, so modular subtraction is safe.
    assign dx     = draw_x - st.x;
    assign dy     = draw_y - st.y;
    assign in_x   = (draw_x >= st.x) && (dx < COORD_W'(SPRITE_W));
    assign in_y   = (draw_y >= st.y) && (dy < COORD_W'(SPRITE_H));
    assign hit_c  = st.active && in_x && in_y;
    assign relx_c = hit_c ? dx : '0;
    assign rely_c = hit_c ? dy : '0;

    assign active       = st.active;
    assign active_nxt_c = st_nxt.active;

endmodule

// File: rtl/bloonpop_ctrl.sv
// Bloon-pop effect controller: slot allocation, per-pixel effect select and RGB-aligned hit flag.
module bloonpop_ctrl
    import bloonpop_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 4,
    parameter int unsigned DURATION  = 8,
    parameter int unsigned ALIGN_LAT = 2
) (
    input  logic       vga_clk,
    input  logic       Reset,
    bloonpop_if.slave  bus
);

    logic [NUM_SLOTS-1:0] active;
    logic [NUM_SLOTS-1:0] active_nxt;
    logic [NUM_SLOTS-1:0] load;
    logic [NUM_SLOTS-1:0] hit;
    coord_t               relx [NUM_SLOTS];
    coord_t               rely [NUM_SLOTS];

    logic                 any_free;
    logic                 hit_any;
    coord_t               win_x;
    coord_t               win_y;
    logic [CNT_W-1:0]     cnt_nxt;

    coord_t               rel_x_q;
    coord_t               rel_y_q;
    logic                 hit_q;
    logic                 drop_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [ALIGN_LAT-1:0] pipe_q;

    for (genvar i = 0; i < int'(NUM_SLOTS); i++) begin : g_slot
        bloonpop_slot #(
            .DURATION (DURATION)
        ) u_slot (
            .clk          (vga_clk),
            .rst          (Reset),
            .load         (load[i]),
            .tick         (bus.frame_tick),
            .ld_x         (bus.pop_x),
            .ld_y         (bus.pop_y),
            .draw_x       (bus.DrawX),
            .draw_y       (bus.DrawY),
            .active       (active[i]),
            .active_nxt_c (active_nxt[i]),
            .hit_c        (hit[i]),
            .relx_c       (relx[i]),
            .rely_c       (rely[i])
        );
    end

    // Lowest-index idle slot takes the request; a slot expiring this cycle still counts as busy.
    always_comb begin
        load     = '0;
        any_free = 1'b0;
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            if (!active[i] && !any_free) begin
                any_free = 1'b1;
                load[i]  = bus.pop_req && !Reset;
            end
        end
    end

    // Descending scan so the lowest-index hitting slot is the last writer.
    always_comb begin
        hit_any = 1'b0;
        win_x   = '0;
        win_y   = '0;
        for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_any = 1'b1;
                win_x   = relx[i];
                win_y   = rely[i];
            end
        end
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            cnt_nxt = cnt_nxt + CNT_W'(active_nxt[i]);
        end
    end

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            rel_x_q <= '0;
            rel_y_q <= '0;
            hit_q   <= 1'b0;
            drop_q  <= 1'b0;
            cnt_q   <= '0;
            pipe_q  <= '0;
        end else begin
            rel_x_q   <= win_x;
            rel_y_q   <= win_y;
            hit_q     <= hit_any;
            drop_q    <= bus.pop_req && !any_free;
            cnt_q     <= cnt_nxt;
            pipe_q[0] <= hit_q;
            for (int i = 1; i < int'(ALIGN_LAT); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign bus.RelativeXP  = rel_x_q;
    assign bus.RelativeYP  = rel_y_q;
    assign bus.pop_hit     = hit_q;
    assign bus.pop_hit_rgb = pipe_q[ALIGN_LAT-1];
    assign bus.pop_drop    = drop_q;
    assign bus.active_cnt  = cnt_q;

endmodule

// File: tb/tb_bloonpop_ctrl.sv
// Scoreboard bench for bloonpop_ctrl: a slot model predicts every output cycle, plus scenario spot checks.
module tb_bloonpop_ctrl;

    localparam int NS  = 4;
    localparam int DUR = 8;
    localparam int SW  = 32;
    localparam int SH  = 32;

    typedef struct {
        bit rst;
        bit hit;
        bit drop;
        int rx;
        int ry;
        int cnt;
    } exp_t;

    logic vga_clk = 1'b0;
    logic Reset;

    bloonpop_if bus ();

    bloonpop_ctrl #(
        .NUM_SLOTS (NS),
        .DURATION  (DUR),
        .ALIGN_LAT (2)
    ) dut (
        .vga_clk (vga_clk),
        .Reset   (Reset),
        .bus     (bus)
    );

    always #5 vga_clk = ~vga_clk;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    bit   hist[$];
    exp_t mon_e;
    bit   mon_rgb;

    bit   m_act [NS];
    int   m_x   [NS];
    int   m_y   [NS];
    int   m_fl  [NS];

    // Scoreboard: one expected entry per clock, compared just after the edge.
    always @(posedge vga_clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            if (mon_e.rst) begin
                hist.delete();
                hist.push_back(1'b0);
                hist.push_back(1'b0);
            end
            hist.push_back(mon_e.hit);
            checks++;
            if (bus.pop_hit !== mon_e.hit) begin
                errors++; $display("FAIL sb_pop_hit t=%0t got %0b exp %0b", $time, bus.pop_hit, mon_e.hit);
            end
            checks++;
            if (bus.RelativeXP !== 10'(mon_e.rx) || bus.RelativeYP !== 10'(mon_e.ry)) begin
                errors++; $display("FAIL sb_rel t=%0t got %0d,%0d exp %0d,%0d", $time, bus.RelativeXP, bus.RelativeYP, mon_e.rx, mon_e.ry);
            end
            checks++;
            if (bus.active_cnt !== 4'(mon_e.cnt)) begin
                errors++; $display("FAIL sb_active_cnt t=%0t got %0d exp %0d", $time, bus.active_cnt, mon_e.cnt);
            end
            checks++;
            if (bus.pop_drop !== mon_e.drop) begin
                errors++; $display("FAIL sb_pop_drop t=%0t got %0b exp %0b", $time, bus.pop_drop, mon_e.drop);
            end
            if (hist.size() >= 3) begin
                mon_rgb = hist.pop_front();
                checks++;
                if (bus.pop_hit_rgb !== mon_rgb) begin
                    errors++; $display("FAIL sb_pop_hit_rgb t=%0t got %0b exp %0b", $time, bus.pop_hit_rgb, mon_rgb);
                end
            end
        end
    end

    // Drive one clock of stimulus, predict its outputs, and return just after the edge.
    task automatic cycle(input bit req, input int px, input int py, input bit tick,
                         input bit rst, input int dx, input int dy);
        exp_t e;
        int   free_i;
        @(negedge vga_clk);
        Reset          = rst;
        bus.pop_req    = req;
        bus.pop_x      = 10'(px);
        bus.pop_y      = 10'(py);
        bus.frame_tick = tick;
        bus.DrawX      = 10'(dx);
        bus.DrawY      = 10'(dy);
        e = '{default: 0};
        e.rst = rst;
        if (!rst) begin
            for (int i = 0; i < NS; i++) begin
                if (!e.hit && m_act[i] && dx >= m_x[i] && dx - m_x[i] < SW
                    && dy >= m_y[i] && dy - m_y[i] < SH) begin
                    e.hit = 1'b1;
                    e.rx  = dx - m_x[i];
                    e.ry  = dy - m_y[i];
                end
            end
        end
        if (rst) begin
            for (int i = 0; i < NS; i++) begin
                m_act[i] = 1'b0; m_fl[i] = 0;
            end
        end else begin
            free_i = -1;
            for (int i = 0; i < NS; i++) if (!m_act[i] && free_i < 0) free_i = i;
            if (tick) begin
                for (int i = 0; i < NS; i++) begin
                    if (m_act[i]) begin
                        m_fl[i]--;
                        if (m_fl[i] == 0) m_act[i] = 1'b0;
                    end
                end
            end
            if (req) begin
                if (free_i >= 0) begin
                    m_act[free_i] = 1'b1; m_x[free_i] = px; m_y[free_i] = py; m_fl[free_i] = DUR;
                end else begin
                    e.drop = 1'b1;
                end
            end
        end
        for (int i = 0; i < NS; i++) e.cnt += int'(m_act[i]);
        exp_q.push_back(e);
        @(posedge vga_clk);
        #2;
    endtask

    task automatic test_reset();
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        checks++;
        if (bus.pop_hit !== 1'b0 || bus.pop_hit_rgb !== 1'b0 || bus.active_cnt !== 4'd0
            || bus.RelativeXP !== 10'd0 || bus.pop_drop !== 1'b0) begin
            errors++; $display("FAIL reset_state: hit=%0b rgb=%0b cnt=%0d relx=%0d drop=%0b exp all 0",
                               bus.pop_hit, bus.pop_hit_rgb, bus.active_cnt, bus.RelativeXP, bus.pop_drop);
        end
    endtask

    task automatic test_basic_hit();
        cycle(0, 0, 0, 0, 0, 1000, 1000);
        cycle(1, 100, 200, 0, 0, 1000, 1000);
        cycle(0, 0, 0, 0, 0, 105, 210);
        checks++;
        if (bus.pop_hit !== 1'b1 || bus.RelativeXP !== 10'd5 || bus.RelativeYP !== 10'd10 || bus.pop_hit_rgb !== 1'b0) begin
            errors++; $display("FAIL basic_hit: hit=%0b rel=%0d,%0d rgb=%0b exp 1 5,10 rgb 0",
                               bus.pop_hit, bus.RelativeXP, bus.RelativeYP, bus.pop_hit_rgb);
        end
        cycle(0, 0, 0, 0, 0, 1000, 1000);
        checks++;
        if (bus.pop_hit_rgb !== 1'b0) begin
            errors++; $display("FAIL basic_rgb_early: rgb=%0b exp 0", bus.pop_hit_rgb);
        end
        cycle(0, 0, 0, 0, 0, 1000, 1000);
        checks++;
        if (bus.pop_hit_rgb !== 1'b1) begin
            errors++; $display("FAIL basic_rgb_aligned: rgb=%0b exp 1", bus.pop_hit_rgb);
        end
    endtask

    task automatic test_boundary();
        cycle(0, 0, 0, 0, 0, 131, 231);
        checks++;
        if (bus.pop_hit !== 1'b1 || bus.RelativeXP !== 10'd31 || bus.RelativeYP !== 10'd31) begin
            errors++; $display("FAIL bound_corner: hit=%0b rel=%0d,%0d exp 1 31,31", bus.pop_hit, bus.RelativeXP, bus.RelativeYP);
        end
        cycle(0, 0, 0, 0, 0, 132, 231);
        checks++;
        if (bus.pop_hit !== 1'b0 || bus.RelativeXP !== 10'd0 || bus.RelativeYP !== 10'd0) begin
            errors++; $display("FAIL bound_right: hit=%0b rel=%0d,%0d exp 0 0,0", bus.pop_hit, bus.RelativeXP, bus.RelativeYP);
        end
        cycle(0, 0, 0, 0, 0, 99, 210);
        checks++;
        if (bus.pop_hit !== 1'b0) begin
            errors++; $display("FAIL bound_left: hit=%0b exp 0", bus.pop_hit);
        end
        cycle(0, 0, 0, 0, 0, 131, 232);
        cycle(0, 0, 0, 0, 0, 100, 199);
    endtask

    task automatic test_expiry();
        for (int t = 0; t < DUR - 1; t++) cycle(0, 0, 0, 1, 0, 105, 210);
        cycle(0, 0, 0, 0, 0, 105, 210);
        checks++;
        if (bus.active_cnt !== 4'd1 || bus.pop_hit !== 1'b1) begin
            errors++; $display("FAIL expiry_7: cnt=%0d hit=%0b exp 1 1", bus.active_cnt, bus.pop_hit);
        end
        cycle(0, 0, 0, 1, 0, 105, 210);
        checks++;
        if (bus.active_cnt !== 4'd0) begin
            errors++; $display("FAIL expiry_8_cnt: cnt=%0d exp 0", bus.active_cnt);
        end
        cycle(0, 0, 0, 0, 0, 105, 210);
        checks++;
        if (bus.pop_hit !== 1'b0) begin
            errors++; $display("FAIL expiry_8_hit: hit=%0b exp 0", bus.pop_hit);
        end
    endtask

    task automatic test_drop();
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 0, 1000, 1000);
        cycle(1, 200, 0, 0, 0, 1000, 1000);
        cycle(1, 10, 10, 0, 0, 1000, 1000);
        cycle(1, 300, 300, 0, 0, 1000, 1000);
        checks++;
        if (bus.active_cnt !== 4'd4 || bus.pop_drop !== 1'b0) begin
            errors++; $display("FAIL drop_full: cnt=%0d drop=%0b exp 4 0", bus.active_cnt, bus.pop_drop);
        end
        cycle(1, 500, 500, 0, 0, 1000, 1000);
        checks++;
        if (bus.pop_drop !== 1'b1 || bus.active_cnt !== 4'd4) begin
            errors++; $display("FAIL drop_pulse: drop=%0b cnt=%0d exp 1 4", bus.pop_drop, bus.active_cnt);
        end
        cycle(0, 0, 0, 0, 0, 20, 20);
        checks++;
        if (bus.pop_drop !== 1'b0 || bus.RelativeXP !== 10'd20 || bus.RelativeYP !== 10'd20) begin
            errors++; $display("FAIL drop_priority: drop=%0b rel=%0d,%0d exp 0 20,20", bus.pop_drop, bus.RelativeXP, bus.RelativeYP);
        end
        cycle(0, 0, 0, 0, 0, 505, 505);
        cycle(0, 0, 0, 0, 0, 215, 5);
    endtask

    task automatic test_coincident();
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(1, 50, 50, 0, 0, 1000, 1000);
        for (int t = 0; t < DUR - 1; t++) cycle(0, 0, 0, 1, 0, 55, 55);
        cycle(1, 300, 100, 1, 0, 55, 55);
        checks++;
        if (bus.active_cnt !== 4'd1 || bus.pop_drop !== 1'b0) begin
            errors++; $display("FAIL coinc_cnt: cnt=%0d drop=%0b exp 1 0", bus.active_cnt, bus.pop_drop);
        end
        cycle(1, 290, 100, 0, 0, 305, 100);
        checks++;
        if (bus.RelativeXP !== 10'd5 || bus.active_cnt !== 4'd2) begin
            errors++; $display("FAIL coinc_slot1: relx=%0d cnt=%0d exp 5 2", bus.RelativeXP, bus.active_cnt);
        end
        cycle(0, 0, 0, 0, 0, 305, 100);
        checks++;
        if (bus.RelativeXP !== 10'd15) begin
            errors++; $display("FAIL coinc_reuse0: relx=%0d exp 15", bus.RelativeXP);
        end
        for (int t = 0; t < DUR - 1; t++) cycle(0, 0, 0, 1, 0, 305, 100);
        checks++;
        if (bus.active_cnt !== 4'd2) begin
            errors++; $display("FAIL coinc_full_dur: cnt=%0d exp 2", bus.active_cnt);
        end
        cycle(0, 0, 0, 1, 0, 305, 100);
        cycle(0, 0, 0, 0, 0, 305, 100);
    endtask

    task automatic test_reset_mid();
        cycle(1, 100, 100, 0, 0, 1000, 1000);
        cycle(0, 0, 0, 0, 0, 110, 110);
        cycle(0, 0, 0, 0, 0, 110, 110);
        checks++;
        if (bus.pop_hit !== 1'b1 || bus.pop_hit_rgb !== 1'b0) begin
            errors++; $display("FAIL rstmid_pre: hit=%0b rgb=%0b exp 1 0", bus.pop_hit, bus.pop_hit_rgb);
        end
        cycle(1, 0, 0, 0, 1, 110, 110);
        checks++;
        if (bus.pop_hit !== 1'b0 || bus.pop_hit_rgb !== 1'b0 || bus.RelativeXP !== 10'd0
            || bus.RelativeYP !== 10'd0 || bus.active_cnt !== 4'd0) begin
            errors++; $display("FAIL rstmid_clear: hit=%0b rgb=%0b rel=%0d,%0d cnt=%0d exp all 0",
                               bus.pop_hit, bus.pop_hit_rgb, bus.RelativeXP, bus.RelativeYP, bus.active_cnt);
        end
        cycle(0, 0, 0, 0, 0, 5, 5);
        checks++;
        if (bus.pop_hit !== 1'b0 || bus.active_cnt !== 4'd0 || bus.pop_hit_rgb !== 1'b0) begin
            errors++; $display("FAIL rstmid_no_alloc: hit=%0b cnt=%0d rgb=%0b exp 0 0 0", bus.pop_hit, bus.active_cnt, bus.pop_hit_rgb);
        end
        cycle(0, 0, 0, 0, 0, 110, 110);
    endtask

    initial begin
        Reset          = 1'b1;
        bus.pop_req    = 1'b0;
        bus.pop_x      = '0;
        bus.pop_y      = '0;
        bus.frame_tick = 1'b0;
        bus.DrawX      = '0;
        bus.DrawY      = '0;
        for (int i = 0; i < NS; i++) begin
            m_act[i] = 1'b0; m_x[i] = 0; m_y[i] = 0; m_fl[i] = 0;
        end
        test_reset();
        test_basic_hit();
        test_boundary();
        test_expiry();
        test_drop();
        test_coincident();
        test_reset_mid();
        cycle(0, 0, 0, 0, 0, 1000, 1000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
